// File: rtl/pin_lock_fsm.sv
// PIN entry lock: compares entered digits with pin_ref, grants a timed unlock,
// counts failed attempts and locks out. Define PIN_TIMEOUT_EN for an inter-digit timeout.
module pin_lock_fsm #(
  parameter int DIGIT_W        = 4,
  parameter int PIN_LEN        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int UNLOCK_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           digit_valid,
  input  logic [DIGIT_W-1:0]             digit,
  input  logic                           clear,
  input  logic [PIN_LEN*DIGIT_W-1:0]     pin_ref,
  output logic                           unlock,
  output logic                           fail,
  output logic                           locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           busy,
  output logic                           timeout
);

  localparam int TRIES_W  = $clog2(MAX_TRIES + 1);
  localparam int CNT_W    = $clog2(PIN_LEN + 1);
  localparam int HOLD_MAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  if (DIGIT_W < 1 || PIN_LEN < 2 || PIN_LEN > 16 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
      LOCK_CYCLES < 1 || UNLOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pin_lock_fsm: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCK,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     digit_cnt, digit_cnt_n;
  logic                 mismatch, mismatch_n;
  logic [TRIES_W-1:0]   tries, tries_n;
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
  logic [DIGIT_W-1:0]   exp_digit;
  logic                 digit_bad;
`ifdef PIN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      digit_cnt <= '0;
      mismatch  <= 1'b0;
      tries     <= TRIES_W'(MAX_TRIES);
      hold_cnt  <= '0;
`ifdef PIN_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      digit_cnt <= digit_cnt_n;
      mismatch  <= mismatch_n;
      tries     <= tries_n;
      hold_cnt  <= hold_cnt_n;
`ifdef PIN_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    digit_cnt_n = digit_cnt;
    mismatch_n  = mismatch;
    tries_n     = tries;
    hold_cnt_n  = '0;
`ifdef PIN_TIMEOUT_EN
    tmo_cnt_n   = '0;
`endif

    // Reference digit for the position about to be accepted (first digit in the MSBs).
    exp_digit = '0;
    for (int i = 0; i < PIN_LEN; i++) begin
      if (digit_cnt == CNT_W'(i)) exp_digit = pin_ref[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
    digit_bad = (digit != exp_digit);

    case (state)
      S_IDLE: begin
        digit_cnt_n = '0;
        mismatch_n  = 1'b0;
        if (digit_valid && !clear) begin
          state_n     = S_ENTRY;
          digit_cnt_n = CNT_W'(1);
          mismatch_n  = digit_bad;
        end
      end
      S_ENTRY: begin
        if (clear) begin
          state_n     = S_IDLE;
          digit_cnt_n = '0;
          mismatch_n  = 1'b0;
        end else if (digit_valid) begin
          mismatch_n = mismatch | digit_bad;
          if (digit_cnt != CNT_W'(PIN_LEN)) digit_cnt_n = digit_cnt + CNT_W'(1);
          if (digit_cnt == CNT_W'(PIN_LEN - 1)) state_n = S_CHECK;
        end
`ifdef PIN_TIMEOUT_EN
        else begin
          // A timeout is routed through CHECK as a forced mismatch.
          tmo_cnt_n = (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) ? tmo_cnt + TMO_W'(1) : tmo_cnt;
          if (tmo_cnt_n == TMO_W'(TIMEOUT_CYCLES)) begin
            state_n    = S_CHECK;
            mismatch_n = 1'b1;
          end
        end
`endif
      end
      S_CHECK: begin
        digit_cnt_n = '0;
        mismatch_n  = 1'b0;
        if (mismatch) begin
          state_n = S_FAIL;
          if (tries != '0) tries_n = tries - TRIES_W'(1);
        end else begin
          state_n = S_UNLOCK;
          tries_n = TRIES_W'(MAX_TRIES);
        end
      end
      S_UNLOCK: begin
        if (hold_cnt == HOLD_W'(UNLOCK_CYCLES - 1)) state_n = S_IDLE;
        else hold_cnt_n = hold_cnt + HOLD_W'(1);
      end
      S_FAIL: begin
        state_n = (tries == '0) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (hold_cnt == HOLD_W'(LOCK_CYCLES - 1)) begin
          state_n = S_IDLE;
          tries_n = TRIES_W'(MAX_TRIES);
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign unlock     = (state == S_UNLOCK);
  assign fail       = (state == S_FAIL);
  assign locked     = (state == S_LOCKOUT);
  assign busy       = (state != S_IDLE);
  assign tries_left = tries;
`ifdef PIN_TIMEOUT_EN
  assign timeout = (state == S_CHECK) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pin_lock_fsm.sv
// Directed testbench for pin_lock_fsm with PIN 1234; expectations are hand-derived
// cycle by cycle (outputs sampled 1 time unit after each rising edge).
module tb_pin_lock_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'h0;
  logic        clear = 1'b0;
  logic [15:0] pin_ref = 16'h1234;
  logic        unlock, fail, locked, busy, timeout;
  logic [1:0]  tries_left;

  int vectors = 0;
  int miscompares = 0;

  pin_lock_fsm #(
    .DIGIT_W(4), .PIN_LEN(4), .MAX_TRIES(3), .LOCK_CYCLES(8),
    .UNLOCK_CYCLES(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .clear(clear),
    .pin_ref(pin_ref), .unlock(unlock), .fail(fail), .locked(locked),
    .tries_left(tries_left), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic clr);
    digit_valid = dv;
    digit       = d;
    clear       = clr;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic enterPin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, p[(3-i)*4 +: 4], 1'b0);
  endtask

  task automatic expectUnlock(input string tag);
    checkOutput({tag, "_check_unlock"}, unlock, 0);
    checkOutput({tag, "_check_busy"}, busy, 1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput({tag, "_unlock1"}, unlock, 1);
    checkOutput({tag, "_tries"}, tries_left, 3);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput({tag, "_unlock2"}, unlock, 1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput({tag, "_unlock_end"}, unlock, 0);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  task automatic expectFail(input string tag, input logic [1:0] tries_after);
    checkOutput({tag, "_check_fail"}, fail, 0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput({tag, "_fail"}, fail, 1);
    checkOutput({tag, "_unlock"}, unlock, 0);
    checkOutput({tag, "_tries"}, tries_left, 32'(tries_after));
  endtask

  initial begin
    $display("[TB] starting pin_lock_fsm test");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_unlock", unlock, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_tries", tries_left, 3);

    // Correct PIN
    enterPin(16'h1234);
    expectUnlock("good");

    // Early mismatch still consumes all four digits
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b0);
    checkOutput("bad1_busy_d2", busy, 1);
    checkOutput("bad1_nofail_d2", fail, 0);
    applyStimulus(1'b1, 4'h3, 1'b0);
    checkOutput("bad1_nofail_d3", fail, 0);
    applyStimulus(1'b1, 4'h4, 1'b0);
    expectFail("bad1", 2'd2);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("bad1_fail_end", fail, 0);
    checkOutput("bad1_idle", busy, 0);

    // Second and third wrong PINs, then lockout
    enterPin(16'h1235);
    expectFail("bad2", 2'd1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("bad2_idle", busy, 0);
    enterPin(16'h4321);
    expectFail("bad3", 2'd0);
    checkOutput("bad3_not_locked_yet", locked, 0);
    applyStimulus(1'b1, 4'h1, 1'b0);
    checkOutput("lock_c1", locked, 1);
    checkOutput("lock_tries0", tries_left, 0);
    for (int i = 2; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0);
      checkOutput($sformatf("lock_c%0d", i), locked, 1);
    end
    applyStimulus(1'b1, 4'h1, 1'b0);
    checkOutput("lock_end", locked, 0);
    checkOutput("lock_end_idle", busy, 0);
    checkOutput("lock_end_tries", tries_left, 3);
    enterPin(16'h1234);
    expectUnlock("after_lock");

    // clear beats a simultaneous digit
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b1);
    checkOutput("clear_idle", busy, 0);
    checkOutput("clear_tries", tries_left, 3);
    checkOutput("clear_nofail", fail, 0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("clear_nofail2", fail, 0);
    enterPin(16'h1234);
    expectUnlock("after_clear");

    // Reset mid-entry restores full tries after an earlier failure
    enterPin(16'h9999);
    expectFail("pre_rst", 2'd2);
    applyStimulus(1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    checkOutput("mid_busy", busy, 1);
    rst = 1'b0;
    applyStimulus(1'b1, 4'h3, 1'b0);
    rst = 1'b1;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_unlock", unlock, 0);
    checkOutput("mrst_fail", fail, 0);
    checkOutput("mrst_locked", locked, 0);
    checkOutput("mrst_timeout", timeout, 0);
    checkOutput("mrst_tries", tries_left, 3);

    // Inter-digit timeout
    applyStimulus(1'b1, 4'h1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput($sformatf("tmo_wait%0d_busy", i), busy, 1);
      checkOutput($sformatf("tmo_wait%0d_timeout", i), timeout, 0);
    end
    applyStimulus(1'b0, 4'h0, 1'b0);
`ifdef PIN_TIMEOUT_EN
    checkOutput("tmo_pulse", timeout, 1);
    checkOutput("tmo_pulse_nofail", fail, 0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("tmo_fail", fail, 1);
    checkOutput("tmo_pulse_end", timeout, 0);
    checkOutput("tmo_tries", tries_left, 2);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("tmo_idle", busy, 0);
`else
    checkOutput("notmo_timeout", timeout, 0);
    checkOutput("notmo_busy", busy, 1);
    repeat (5) applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("notmo_still_busy", busy, 1);
    checkOutput("notmo_nofail", fail, 0);
    checkOutput("notmo_tries", tries_left, 3);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("notmo_cleared", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pin_lock_fsm.md
PIN_LOCK_FSM -- requirements
Module: pin_lock_fsm

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4: width of one entered digit.
REQ-002 SHALL have parameter PIN_LEN, default 4, range 2..16: digits per PIN.
REQ-003 SHALL have parameter MAX_TRIES, default 3, range 1..15: failed attempts allowed before lockout.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, minimum 1: lockout duration in cycles.
REQ-005 SHALL have parameter UNLOCK_CYCLES, default 1, minimum 1: unlock hold duration in cycles.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 64, minimum 1: inter-digit timeout; used only under PIN_TIMEOUT_EN.
REQ-007 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-009 SHALL have port digit_valid  input  1: digit strobe, one digit per high cycle.
REQ-010 SHALL have port digit  input  DIGIT_W: entered digit, qualified by digit_valid.
REQ-011 SHALL have port clear  input  1: abort the current entry.
REQ-012 SHALL have port pin_ref  input  PIN_LEN*DIGIT_W: stored PIN; first digit in the MSB slice; stable during entry.
REQ-013 SHALL have port unlock  output  1: high while in UNLOCK.
REQ-014 SHALL have port fail  output  1: one-cycle pulse per failed attempt.
REQ-015 SHALL have port locked  output  1: high while in LOCKOUT.
REQ-016 SHALL have port tries_left  output  $clog2(MAX_TRIES+1): remaining attempts.
REQ-017 SHALL have port busy  output  1: high whenever the state is not IDLE.
REQ-018 SHALL have port timeout  output  1: one-cycle pulse on inter-digit timeout; constant 0 without PIN_TIMEOUT_EN.

Function
REQ-019 SHALL implement states IDLE, ENTRY, CHECK, UNLOCK, FAIL, LOCKOUT; all outputs are decoded from registered state and counters.
REQ-020 In IDLE, a digit_valid with clear low SHALL accept digit 0 and move to ENTRY, with digit count 1.
REQ-021 Digit i SHALL be compared with pin_ref[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W] on acceptance; a sticky mismatch flag SHALL record any difference.
REQ-022 All PIN_LEN digits SHALL be consumed before any verdict; an early mismatch SHALL NOT shorten entry.
REQ-023 Acceptance of digit PIN_LEN-1 SHALL move to CHECK; CHECK lasts exactly 1 cycle; unlock or fail asserts 2 cycles after the edge that accepts the last digit.
REQ-024 CHECK with no mismatch SHALL go to UNLOCK for UNLOCK_CYCLES cycles, reload tries_left to MAX_TRIES, then go to IDLE.
REQ-025 CHECK with a mismatch SHALL decrement tries_left and go to FAIL; fail is high for the one FAIL cycle.
REQ-026 FAIL SHALL go to LOCKOUT if tries_left is 0, else to IDLE.
REQ-027 LOCKOUT SHALL last LOCK_CYCLES cycles, then reload tries_left to MAX_TRIES and go to IDLE.
REQ-028 clear in ENTRY SHALL return to IDLE next cycle with no try consumed and mismatch/count zeroed; clear wins over a simultaneous digit_valid.
REQ-029 digit_valid and clear SHALL be ignored in CHECK, UNLOCK, FAIL and LOCKOUT.
REQ-030 Counters SHALL saturate and never wrap; tries_left never underflows below 0.

Reset
REQ-031 On a rising clk edge with rst low, the block SHALL enter IDLE: tries_left=MAX_TRIES; digit count, mismatch flag and all timers 0; unlock, fail, locked, busy and timeout all 0.
REQ-032 Reset SHALL override all activity in any state, including mid-entry and mid-lockout; the interrupted attempt is discarded uncounted.

Configuration
REQ-033 With macro PIN_TIMEOUT_EN defined, a timer SHALL clear on each accepted digit in ENTRY; reaching TIMEOUT_CYCLES idle cycles SHALL pulse timeout and follow the mismatch path (decrement tries_left, then FAIL).
REQ-034 Without PIN_TIMEOUT_EN, no timer logic SHALL exist; ENTRY waits indefinitely; timeout is tied 0.

Verification
Parameters for all scenarios: DIGIT_W=4, PIN_LEN=4, MAX_TRIES=3, LOCK_CYCLES=8, UNLOCK_CYCLES=2, TIMEOUT_CYCLES=10, pin_ref=16'h1234.
REQ-035 Digits 1,2,3,4 on consecutive cycles -> unlock high 2 cycles starting 2 cycles after digit 4; tries_left=3.
REQ-036 Digits 1,9,3,4 -> 4 digits consumed, 1-cycle fail pulse, tries_left 3->2, back to IDLE.
REQ-037 Three wrong PINs -> third fail followed by locked high 8 cycles; digits during lockout ignored; tries_left=3 afterwards; PIN 1234 then unlocks.
REQ-038 Digits 1,2 then clear with digit_valid (digit 3) on the same cycle -> IDLE, tries_left unchanged, no fail; full 1234 then unlocks.
REQ-039 Digits 1,2 then rst low 1 cycle -> IDLE with all outputs 0 and tries_left=3.
REQ-040 With PIN_TIMEOUT_EN: digit 1, then 10 idle cycles -> timeout and fail pulses, tries_left=2; without the macro, same stimulus stays in ENTRY with busy=1.
